// File: rtl/press_req_if.sv
// Request handshake between the button conditioner and the LFU counter stage.
interface press_req_if;
  logic       req_valid;
  logic [2:0] req_idx;
  logic       req_ready;

  modport master (output req_valid, output req_idx, input req_ready);
  modport slave  (input req_valid, input req_idx, output req_ready);
endinterface

// File: rtl/press_conditioner.sv
// Synchronises and debounces five push buttons. Each clean press becomes a pending
// request, and pending requests are handed out one at a time over a valid/ready handshake.
module press_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b1,
  input  logic               b2,
  input  logic               b3,
  input  logic               b4,
  input  logic               b5,
  press_req_if.master        req,
  output logic [4:0]         pressed,
  output logic               overrun
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  // Lowest set bit wins, so simultaneous presses are served in ascending channel order.
  function automatic logic [2:0] lowest_idx(input logic [4:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
      else      r = r;
    end
    return r;
  endfunction

  logic [4:0]    raw;
  logic [4:0]    sync_q [SYNC_STAGES];
  logic [4:0]    sync;
  logic [4:0]    stable;
  logic [4:0]    stable_nxt;
  logic [CW-1:0] cnt     [5];
  logic [CW-1:0] cnt_nxt [5];
  logic [4:0]    rise;
  logic [4:0]    pending;
  logic [4:0]    pending_nxt;
  logic [4:0]    clear;
  logic          overrun_nxt;
  state_t        state;
  state_t        state_nxt;
  logic          offer_valid;
  logic          offer_valid_nxt;
  logic [2:0]    offer_idx;
  logic [2:0]    offer_idx_nxt;

  assign raw           = {b5, b4, b3, b2, b1};
  assign sync          = sync_q[SYNC_STAGES-1];
  assign pressed       = stable;
  assign req.req_valid = offer_valid;
  assign req.req_idx   = offer_idx;

  // Synchroniser chains: raw buttons are only used after SYNC_STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 5'b0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Debounce decision per channel: accept a new level only after it persists long enough.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync[i] == stable[i]) begin
        cnt_nxt[i] = {CW{1'b0}};
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = sync[i];
        cnt_nxt[i]    = {CW{1'b0}};
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
    rise = stable_nxt & ~stable;
  end

  // FSM next state and offer outputs; IDLE pulls the lowest pending request.
  always_comb begin
    state_nxt       = state;
    offer_valid_nxt = offer_valid;
    offer_idx_nxt   = offer_idx;
    clear           = 5'b0;
    case (state)
      IDLE: begin
        offer_valid_nxt = 1'b0;
        if (pending != 5'b0) begin
          offer_idx_nxt   = lowest_idx(pending);
          clear           = 5'b00001 << offer_idx_nxt;
          offer_valid_nxt = 1'b1;
          state_nxt       = OFFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        offer_valid_nxt = 1'b1;
        if (req.req_ready) begin
          offer_valid_nxt = 1'b0;
          state_nxt       = IDLE;
        end else begin
          state_nxt = OFFER;
        end
      end
      default: begin
        offer_valid_nxt = 1'b0;
        state_nxt       = IDLE;
      end
    endcase
    // A new press beats a same-edge clear; a press onto a still-pending bit is merged.
    pending_nxt = (pending & ~clear) | rise;
    overrun_nxt = |(rise & pending & ~clear);
  end

  // State, debounce, pending and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable      <= 5'b0;
      for (int i = 0; i < 5; i++) cnt[i] <= {CW{1'b0}};
      pending     <= 5'b0;
      state       <= IDLE;
      offer_valid <= 1'b0;
      offer_idx   <= 3'd0;
      overrun     <= 1'b0;
    end else begin
      stable      <= stable_nxt;
      for (int i = 0; i < 5; i++) cnt[i] <= cnt_nxt[i];
      pending     <= pending_nxt;
      state       <= state_nxt;
      offer_valid <= offer_valid_nxt;
      offer_idx   <= offer_idx_nxt;
      overrun     <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_press_conditioner.sv
// Self-checking bench for press_conditioner with short debounce (4 cycles, 2 sync stages).
module tb_press_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;
  logic [4:0] pressed;
  logic       overrun;

  press_req_if rq();

  press_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .b1(btn[0]), .b2(btn[1]), .b3(btn[2]), .b4(btn[3]), .b5(btn[4]),
    .req(rq), .pressed(pressed), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int hs_cnt   = 0;
  int ovr_cnt  = 0;
  int sb [$];

  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [2:0] prev_idx   = 3'd0;

  typedef struct {
    logic [4:0] mask;
    logic [4:0] exp_pressed;
    int         exp_reqs;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_mask(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i]) sb.push_back(i);
  endtask

  // Clean press-and-release; the expected requests go to the scoreboard when driven.
  task automatic press(input logic [4:0] m, input bit expect_req);
    if (expect_req) push_mask(m);
    btn = m;
    tick(8);
    btn = 5'b0;
    tick(8);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    #1;
  endtask

  // Monitor: pops the scoreboard on each accepted request, checks idx hold and idle gap.
  initial begin
    forever begin
      logic hs;
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (overrun) ovr_cnt++;
        if (prev_hs) check("idle_gap", 32'(rq.req_valid), 32'd0);
        else if (prev_valid && rq.req_valid) check("idx_hold", 32'(rq.req_idx), 32'(prev_idx));
        hs = rq.req_valid && rq.req_ready;
        if (hs) begin
          hs_cnt++;
          check("req_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) check("req_idx", 32'(rq.req_idx), 32'(sb.pop_front()));
        end
        prev_valid = rq.req_valid;
        prev_idx   = rq.req_idx;
        prev_hs    = hs;
      end
    end
  end

  initial begin
    vec_t vecs [5];
    int   h0;
    int   o0;
    logic seen;

    vecs[0] = '{mask: 5'b00001, exp_pressed: 5'b00001, exp_reqs: 1};
    vecs[1] = '{mask: 5'b10010, exp_pressed: 5'b10010, exp_reqs: 2};
    vecs[2] = '{mask: 5'b11111, exp_pressed: 5'b11111, exp_reqs: 5};
    vecs[3] = '{mask: 5'b00100, exp_pressed: 5'b00100, exp_reqs: 1};
    vecs[4] = '{mask: 5'b01010, exp_pressed: 5'b01010, exp_reqs: 2};

    rst = 1'b1;
    btn = 5'b0;
    rq.req_ready = 1'b0;
    tick(3);
    check("rst_valid",   32'(rq.req_valid), 32'd0);
    check("rst_idx",     32'(rq.req_idx),   32'd0);
    check("rst_pressed", 32'(pressed),      32'd0);
    check("rst_overrun", 32'(overrun),      32'd0);
    rst = 1'b0;
    tick(2);

    // Latency: b3 held from edge 1.
    rq.req_ready = 1'b1;
    h0 = hs_cnt;
    sb.push_back(2);
    btn = 5'b00100;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 5) check("lat_stable_e5", 32'(pressed[2]), 32'd0);
      if (e == 6) begin
        check("lat_stable_e6", 32'(pressed[2]), 32'd1);
        check("lat_valid_e6", 32'(rq.req_valid), 32'd0);
      end
      if (e == 7) begin
        check("lat_valid_e7", 32'(rq.req_valid), 32'd1);
        check("lat_idx_e7", 32'(rq.req_idx), 32'd2);
      end
    end
    #1;
    tick(6);
    btn = 5'b0;
    tick(12);
    wait_drain("lat_drain");
    check("lat_one_req", 32'(hs_cnt - h0), 32'd1);

    // Bounce: b1 toggles every 2 cycles, never long enough to be accepted.
    h0 = hs_cnt;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      btn[0] = ~btn[0];
      tick(1);
      seen = seen | pressed[0];
      tick(1);
      seen = seen | pressed[0];
    end
    tick(12);
    check("bounce_pressed", 32'(seen | pressed[0]), 32'd0);
    check("bounce_no_req", 32'(hs_cnt - h0), 32'd0);

    // Table-driven presses with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      h0 = hs_cnt;
      push_mask(vecs[v].mask);
      btn = vecs[v].mask;
      tick(8);
      check($sformatf("tbl%0d_pressed", v), 32'(pressed), 32'(vecs[v].exp_pressed));
      btn = 5'b0;
      tick(8);
      check($sformatf("tbl%0d_released", v), 32'(pressed), 32'd0);
      wait_drain($sformatf("tbl%0d_drain", v));
      check($sformatf("tbl%0d_reqs", v), 32'(hs_cnt - h0), 32'(vecs[v].exp_reqs));
    end

    // Consumer stalled: held offer, one pending merge, one overrun.
    rq.req_ready = 1'b0;
    h0 = hs_cnt;
    o0 = ovr_cnt;
    press(5'b01000, 1'b1);
    check("stall_valid", 32'(rq.req_valid), 32'd1);
    check("stall_idx", 32'(rq.req_idx), 32'd3);
    press(5'b01000, 1'b1);
    check("stall_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    press(5'b01000, 1'b0);
    check("stall_one_ovr", 32'(ovr_cnt - o0), 32'd1);
    rq.req_ready = 1'b1;
    tick(2);
    wait_drain("stall_drain");
    tick(6);
    check("stall_two_reqs", 32'(hs_cnt - h0), 32'd2);

    // Reset during an offer with more requests pending.
    rq.req_ready = 1'b0;
    press(5'b00111, 1'b1);
    check("mid_valid", 32'(rq.req_valid), 32'd1);
    check("mid_idx", 32'(rq.req_idx), 32'd0);
    sb.delete();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(rq.req_valid), 32'd0);
    check("mid_rst_pressed", 32'(pressed), 32'd0);
    rq.req_ready = 1'b1;
    h0 = hs_cnt;
    tick(20);
    check("mid_rst_no_req", 32'(hs_cnt - h0), 32'd0);

    // New b2 press lands on the edge IDLE loads the earlier b2 request.
    rq.req_ready = 1'b0;
    h0 = hs_cnt;
    o0 = ovr_cnt;
    press(5'b00001, 1'b1);
    press(5'b00010, 1'b1);
    sb.push_back(1);
    btn = 5'b00010;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 4) rq.req_ready = 1'b1;
    end
    check("same_edge_valid", 32'(rq.req_valid), 32'd1);
    check("same_edge_idx", 32'(rq.req_idx), 32'd1);
    check("same_edge_ovr", 32'(overrun), 32'd0);
    tick(2);
    btn = 5'b0;
    tick(10);
    wait_drain("same_edge_drain");
    check("same_edge_reqs", 32'(hs_cnt - h0), 32'd3);
    check("same_edge_no_ovr", 32'(ovr_cnt - o0), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
